switch_mem_regs: RTL and testbench



---
 rtl/switch_cfg_pkg.sv | 18 +
 rtl/mem_slave_fsm.sv | 63 ++++++
 rtl/switch_mem_regs.sv | 103 ++++++++++
 tb/tb_switch_mem_regs.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/switch_cfg_pkg.sv
// rtl/switch_cfg_pkg.sv - shared address map, access direction and slave FSM state encoding
package switch_cfg_pkg;

    localparam logic [7:0] ADDR_PORT_BASE = 8'h00;
    localparam logic [7:0] ADDR_CTRL      = 8'h10;
    localparam logic [7:0] ADDR_ERR_CNT   = 8'h11;

    localparam logic MEM_WRITE = 1'b1;
    localparam logic MEM_READ  = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        RELEASE
    } mem_state_t;

endpackage

// File: rtl/mem_slave_fsm.sv
// rtl/mem_slave_fsm.sv - memory slave handshake: request capture, wait states, one-shot commit and ack
module mem_slave_fsm
    import switch_cfg_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mem_sel_en,
    input  logic [7:0] mem_addr,
    input  logic [7:0] mem_wr_data,
    input  logic       mem_wr_rd_s,
    output logic       commit,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    output logic       cmd_write,
    output logic       mem_ack
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

    mem_state_t state_q;
    mem_state_t state_d;
    logic [3:0] cnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_sel_en) state_d = NO_WAIT ? ACK : WAIT;
            WAIT:    if (cnt_q <= 4'd1) state_d = ACK;
            ACK:     state_d = RELEASE;
            RELEASE: if (!mem_sel_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The ACK state lasts one cycle; its closing edge commits the access and raises mem_ack
    assign commit = (state_q == ACK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            cmd_addr  <= 8'h00;
            cmd_data  <= 8'h00;
            cmd_write <= 1'b0;
            mem_ack   <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_ack <= commit;
            if (state_q == IDLE && mem_sel_en) begin
                cmd_addr  <= mem_addr;
                cmd_data  <= mem_wr_data;
                cmd_write <= mem_wr_rd_s;
                cnt_q     <= WAIT_INIT;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

endmodule

// File: rtl/switch_mem_regs.sv
// rtl/switch_mem_regs.sv - switch configuration register bank: port addresses, CTRL enable, ERR_CNT
module switch_mem_regs
    import switch_cfg_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_sel_en,
    input  logic [7:0]             mem_addr,
    input  logic [7:0]             mem_wr_data,
    input  logic                   mem_wr_rd_s,
    output logic [7:0]             mem_rd_data,
    output logic                   mem_ack,
    output logic [NUM_PORTS*8-1:0] port_addr_o,
    output logic                   sw_enable_o
);

    logic       commit;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       cmd_write;

    logic [NUM_PORTS-1:0][7:0] port_q;
    logic                      ctrl_en_q;
    logic [7:0]                err_cnt_q;

    logic [NUM_PORTS-1:0] port_sel;
    logic [7:0]           port_rd;
    logic                 port_hit;

    mem_slave_fsm #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_sel_en  (mem_sel_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_rd_s (mem_wr_rd_s),
        .commit      (commit),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_write   (cmd_write),
        .mem_ack     (mem_ack)
    );

    always_comb begin
        port_sel = '0;
        port_rd  = 8'h00;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (cmd_addr == ADDR_PORT_BASE + 8'(i)) begin
                port_sel[i] = 1'b1;
                port_rd     = port_q[i];
            end
        end
    end

    assign port_hit = |port_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_q      <= '0;
            ctrl_en_q   <= 1'b0;
            err_cnt_q   <= 8'h00;
            mem_rd_data <= 8'h00;
        end else if (commit) begin
            if (port_hit) begin
                if (cmd_write == MEM_WRITE) begin
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (port_sel[i]) port_q[i] <= cmd_data;
                    end
                    mem_rd_data <= 8'h00;
                end else begin
                    mem_rd_data <= port_rd;
                end
            end else if (cmd_addr == ADDR_CTRL) begin
                if (cmd_write == MEM_WRITE) begin
                    ctrl_en_q   <= cmd_data[0];
                    mem_rd_data <= 8'h00;
                end else begin
                    mem_rd_data <= {7'b0, ctrl_en_q};
                end
            end else if (cmd_addr == ADDR_ERR_CNT) begin
                // Read-to-clear; writes are accepted but have no effect
                if (cmd_write == MEM_READ) begin
                    mem_rd_data <= err_cnt_q;
                    err_cnt_q   <= 8'h00;
                end else begin
                    mem_rd_data <= 8'h00;
                end
            end else begin
                mem_rd_data <= 8'h00;
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign port_addr_o = port_q;
    assign sw_enable_o = ctrl_en_q;

endmodule

// File: tb/tb_switch_mem_regs.sv
// tb/tb_switch_mem_regs.sv - randomized and directed checks of switch_mem_regs against a behavioural model
module tb_switch_mem_regs;

    localparam int NP = 4;
    localparam int W  = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_sel_en = 1'b0;
    logic [7:0]    mem_addr = 8'h00;
    logic [7:0]    mem_wr_data = 8'h00;
    logic          mem_wr_rd_s = 1'b0;
    logic [7:0]    mem_rd_data;
    logic          mem_ack;
    logic [NP*8-1:0] port_addr_o;
    logic          sw_enable_o;

    switch_mem_regs #(
        .NUM_PORTS   (NP),
        .WAIT_CYCLES (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_sel_en  (mem_sel_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_rd_s (mem_wr_rd_s),
        .mem_rd_data (mem_rd_data),
        .mem_ack     (mem_ack),
        .port_addr_o (port_addr_o),
        .sw_enable_o (sw_enable_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [7:0] m_port [NP];
    logic       m_en  = 1'b0;
    logic [7:0] m_err = 8'h00;
    logic [7:0] m_rd  = 8'h00;

    bit         pending = 1'b0;
    int         ack_at  = 0;
    logic [7:0] p_addr, p_data;
    logic       p_wr;

    initial for (int i = 0; i < NP; i++) m_port[i] = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NP; i++) m_port[i] = 8'h00;
        m_en  = 1'b0;
        m_err = 8'h00;
        m_rd  = 8'h00;
    endfunction

    function automatic void model_access(input logic [7:0] a, input logic [7:0] d, input logic wr);
        if (int'(a) < NP) begin
            if (wr) begin m_port[int'(a)] = d; m_rd = 8'h00; end
            else m_rd = m_port[int'(a)];
        end else if (a == 8'h10) begin
            if (wr) begin m_en = d[0]; m_rd = 8'h00; end
            else m_rd = {7'b0, m_en};
        end else if (a == 8'h11) begin
            if (wr) m_rd = 8'h00;
            else begin m_rd = m_err; m_err = 8'h00; end
        end else begin
            m_rd = 8'h00;
            if (m_err < 8'hFF) m_err = m_err + 8'd1;
        end
    endfunction

    function automatic logic [NP*8-1:0] model_ports();
        logic [NP*8-1:0] r;
        for (int i = 0; i < NP; i++) r[8*i +: 8] = m_port[i];
        return r;
    endfunction

    // Cycle-by-cycle compare: ack only on the predicted edge, config outputs always tracking the model
    always @(negedge clk) begin
        bit exp_ack;
        exp_ack = pending && (cyc == ack_at);
        if (exp_ack) begin
            model_access(p_addr, p_data, p_wr);
            pending = 1'b0;
        end
        chk("mem_ack", {31'b0, mem_ack}, {31'b0, exp_ack});
        chk("mem_rd_data", {24'b0, mem_rd_data}, {24'b0, m_rd});
        chk("port_addr_o", 32'(port_addr_o), 32'(model_ports()));
        chk("sw_enable_o", {31'b0, sw_enable_o}, {31'b0, m_en});
    end

    task automatic access(input logic [7:0] a, input logic [7:0] d, input logic wr,
                          input int hold, output logic [7:0] rd);
        @(posedge clk); #2;
        mem_addr    = a;
        mem_wr_data = d;
        mem_wr_rd_s = wr;
        mem_sel_en  = 1'b1;
        p_addr = a; p_data = d; p_wr = wr;
        ack_at  = cyc + 2 + W;
        pending = 1'b1;
        @(posedge clk); #2;
        // Inputs after the capture edge must not affect the access
        mem_addr    = 8'($urandom);
        mem_wr_data = 8'($urandom);
        mem_wr_rd_s = 1'($urandom);
        while (cyc < ack_at) begin @(posedge clk); #2; end
        rd = mem_rd_data;
        repeat (hold) begin @(posedge clk); #2; end
        mem_sel_en = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] a;
        int         sel;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        access(8'h00, 8'h00, 1'b0, 0, rd);
        chk("reset_read_p0", {24'b0, rd}, 32'h0);
        chk("reset_ports", 32'(port_addr_o), 32'h0);
        chk("reset_enable", {31'b0, sw_enable_o}, 32'h0);

        access(8'h02, 8'hA5, 1'b1, 0, rd);
        chk("write_rd_zero", {24'b0, rd}, 32'h0);
        chk("port2_written", 32'(port_addr_o), 32'h00A5_0000);
        access(8'h02, 8'h00, 1'b0, 0, rd);
        chk("port2_read", {24'b0, rd}, 32'hA5);

        access(8'h10, 8'hFF, 1'b1, 0, rd);
        chk("ctrl_enable", {31'b0, sw_enable_o}, 32'h1);
        access(8'h10, 8'h00, 1'b0, 0, rd);
        chk("ctrl_read", {24'b0, rd}, 32'h01);

        access(8'h11, 8'h00, 1'b0, 0, rd);
        for (int i = 0; i < 3; i++) begin
            access(8'h40, 8'($urandom), 1'($urandom), 0, rd);
            chk("unmapped_rd", {24'b0, rd}, 32'h0);
        end
        access(8'h11, 8'h00, 1'b0, 0, rd);
        chk("err_cnt_three", {24'b0, rd}, 32'h03);
        access(8'h11, 8'h00, 1'b0, 0, rd);
        chk("err_cnt_cleared", {24'b0, rd}, 32'h00);

        access(8'h01, 8'h3C, 1'b1, 10, rd);
        access(8'h01, 8'h00, 1'b0, 0, rd);
        chk("held_then_read", {24'b0, rd}, 32'h3C);

        // Reset while the write of 0x00=0x77 sits in WAIT
        @(posedge clk); #2;
        mem_addr = 8'h00; mem_wr_data = 8'h77; mem_wr_rd_s = 1'b1; mem_sel_en = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        mem_sel_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #2 chk("abort_port0", {24'b0, port_addr_o[7:0]}, 32'h0);
        access(8'h00, 8'h00, 1'b0, 0, rd);
        chk("abort_read_p0", {24'b0, rd}, 32'h0);

        for (int i = 0; i < 300; i++) access(8'h80, 8'($urandom), 1'($urandom), 0, rd);
        access(8'h11, 8'h00, 1'b0, 0, rd);
        chk("err_cnt_saturated", {24'b0, rd}, 32'hFF);

        for (int i = 0; i < 200; i++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0:       a = 8'($urandom_range(0, NP - 1));
                1:       a = 8'($urandom_range(0, 7));
                2:       a = 8'h10;
                3:       a = 8'h11;
                default: a = 8'($urandom);
            endcase
            access(a, 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), rd);
        end

        repeat (4) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
